// File: rtl/n1_dsp_iter.sv
// rtl/n1_dsp_iter.sv - iterative shift-add DSP responder for the ALU alu2dsp/dsp2alu interface
// Registers the add/sub result at capture and computes a 16x16 signed/unsigned product over N=16/STEPS cycles.
module n1_dsp_iter #(
  parameter int STEPS = 1
) (
  input  logic        clk_i,
  input  logic        sync_rst_i,
  input  logic        alu2dsp_req_i,
  input  logic        alu2dsp_add_sel_i,
  input  logic        alu2dsp_mul_sel_i,
  input  logic [15:0] alu2dsp_add_opd0_i,
  input  logic [15:0] alu2dsp_add_opd1_i,
  input  logic [15:0] alu2dsp_mul_opd0_i,
  input  logic [15:0] alu2dsp_mul_opd1_i,
  output logic        dsp2alu_busy_o,
  output logic        dsp2alu_ack_o,
  output logic [31:0] dsp2alu_add_res_o,
  output logic [31:0] dsp2alu_mul_res_o
);

  localparam int         N    = 16 / STEPS;
  localparam logic [3:0] LAST = 4'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [31:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] add_res_q, add_res_d;
  logic [31:0] mul_res_q, mul_res_d;

  logic [31:0] partial;
  logic [15:0] mag0, mag1;

  // Operand magnitudes; |-32768| fits as 16'h8000 unsigned.
  always_comb begin
    mag0 = alu2dsp_mul_opd0_i;
    mag1 = alu2dsp_mul_opd1_i;
    if (alu2dsp_mul_sel_i && alu2dsp_mul_opd0_i[15]) mag0 = 16'd0 - alu2dsp_mul_opd0_i;
    if (alu2dsp_mul_sel_i && alu2dsp_mul_opd1_i[15]) mag1 = 16'd0 - alu2dsp_mul_opd1_i;
  end

  always_comb begin
    partial = 32'd0;
    for (int j = 0; j < STEPS; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    add_res_d = add_res_q;
    mul_res_d = mul_res_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (alu2dsp_req_i) begin
          add_res_d = alu2dsp_add_sel_i
                    ? ({16'd0, alu2dsp_add_opd0_i} - {16'd0, alu2dsp_add_opd1_i})
                    : ({16'd0, alu2dsp_add_opd0_i} + {16'd0, alu2dsp_add_opd1_i});
          neg_d    = alu2dsp_mul_sel_i & (alu2dsp_mul_opd0_i[15] ^ alu2dsp_mul_opd1_i[15]);
          mcand_d  = {16'd0, mag0};
          mplier_d = mag1;
          acc_d    = 32'd0;
          cnt_d    = 4'd0;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << STEPS;
        mplier_d = mplier_q >> STEPS;
        if (cnt_q == LAST) begin
          cnt_d   = 4'd0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        mul_res_d = neg_q ? (32'd0 - acc_q) : acc_q;
        state_d   = S_DONE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      neg_q     <= 1'b0;
      mcand_q   <= 32'd0;
      mplier_q  <= 16'd0;
      acc_q     <= 32'd0;
      add_res_q <= 32'd0;
      mul_res_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      add_res_q <= add_res_d;
      mul_res_q <= mul_res_d;
    end
  end

  assign dsp2alu_busy_o    = (state_q == S_MUL) || (state_q == S_FIX);
  assign dsp2alu_ack_o     = (state_q == S_DONE);
  assign dsp2alu_add_res_o = add_res_q;
  assign dsp2alu_mul_res_o = mul_res_q;

endmodule

// File: tb/tb_n1_dsp_iter.sv
// tb/tb_n1_dsp_iter.sv - scoreboard bench for n1_dsp_iter across all STEPS values
module tb_n1_dsp_iter;

  localparam int NI = 5;

  logic        clk;
  logic        rst;
  logic        req;
  logic        add_sel;
  logic        mul_sel;
  logic [15:0] a0, a1, m0, m1;
  logic        busy    [NI];
  logic        ack     [NI];
  logic [31:0] add_res [NI];
  logic [31:0] mul_res [NI];

  int total = 0;
  int bad   = 0;
  int ack_cnt     [NI];
  int outstanding [NI];

  typedef struct packed {
    logic [63:0] t;
    logic [31:0] add;
    logic [31:0] mul;
  } exp_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic sub, input logic smul,
                                            input logic [15:0] x0, input logic [15:0] x1,
                                            input logic [15:0] y0, input logic [15:0] y1);
    longint ar, p;
    if (sub) ar = longint'(x0) - longint'(x1);
    else     ar = longint'(x0) + longint'(x1);
    if (smul) p = longint'($signed(y0)) * longint'($signed(y1));
    else      p = longint'(y0) * longint'(y1);
    return {ar[31:0], p[31:0]};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int ST = 1 << g;
    localparam int NC = 16 / ST;
    exp_t q[$];

    n1_dsp_iter #(.STEPS(ST)) dut (
      .clk_i              (clk),
      .sync_rst_i         (rst),
      .alu2dsp_req_i      (req),
      .alu2dsp_add_sel_i  (add_sel),
      .alu2dsp_mul_sel_i  (mul_sel),
      .alu2dsp_add_opd0_i (a0),
      .alu2dsp_add_opd1_i (a1),
      .alu2dsp_mul_opd0_i (m0),
      .alu2dsp_mul_opd1_i (m1),
      .dsp2alu_busy_o     (busy[g]),
      .dsp2alu_ack_o      (ack[g]),
      .dsp2alu_add_res_o  (add_res[g]),
      .dsp2alu_mul_res_o  (mul_res[g])
    );

    // Request accepted whenever the responder is not busy.
    always @(posedge clk) begin
      exp_t e;
      if (rst) begin
        q.delete();
        outstanding[g] = 0;
      end else if (req && !busy[g]) begin
        e.t = $time;
        {e.add, e.mul} = ref_model(add_sel, mul_sel, a0, a1, m0, m1);
        q.push_back(e);
        outstanding[g]++;
      end
    end

    always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
        if (ack[g] && busy[g]) check($sformatf("s%0d ack_while_busy", ST), 64'd1, 64'd0);
        if (ack[g]) begin
          ack_cnt[g]++;
          if (q.size() == 0) begin
            check($sformatf("s%0d unexpected_ack", ST), 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            outstanding[g]--;
            check($sformatf("s%0d add_res", ST), 64'(add_res[g]), 64'(e.add));
            check($sformatf("s%0d mul_res", ST), 64'(mul_res[g]), 64'(e.mul));
            check($sformatf("s%0d latency_ns", ST), $time - e.t, 64'(10 * (NC + 1) + 5));
          end
        end
      end
    end
  end

  task automatic issue(input logic s, input logic sm, input logic [15:0] x0, input logic [15:0] x1,
                       input logic [15:0] y0, input logic [15:0] y1);
    @(posedge clk); #1;
    add_sel = s; mul_sel = sm; a0 = x0; a1 = x1; m0 = y0; m1 = y1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    add_sel = 1'($urandom); mul_sel = 1'($urandom);
    a0 = 16'($urandom); a1 = 16'($urandom);
    m0 = 16'($urandom); m1 = 16'($urandom);
    case ($urandom_range(0, 5))
      0: m0 = 16'h8000;
      1: m1 = 16'h0000;
      2: m0 = 16'hFFFF;
      default: ;
    endcase
  endtask

  task automatic check_idle_zero(input string tag);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s busy%0d", tag, k), 64'(busy[k]), 64'd0);
      check($sformatf("%s ack%0d", tag, k), 64'(ack[k]), 64'd0);
      check($sformatf("%s add%0d", tag, k), 64'(add_res[k]), 64'd0);
      check($sformatf("%s mul%0d", tag, k), 64'(mul_res[k]), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; add_sel = 1'b0; mul_sel = 1'b0;
    a0 = '0; a1 = '0; m0 = '0; m1 = '0;
    for (int k = 0; k < NI; k++) begin ack_cnt[k] = 0; outstanding[k] = 0; end
    wait_cycles(3);
    check_idle_zero("reset");
    rst = 1'b0;

    issue(1'b0, 1'b0, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_cycles(20);
    check("t1 mul", 64'(mul_res[0]), 64'h0000_0000_FFFE_0001);
    check("t1 add", 64'(add_res[0]), 64'h0000_0000_0001_0000);

    issue(1'b0, 1'b1, 16'h0002, 16'h0003, 16'h8000, 16'h8000);
    wait_cycles(20);
    check("t2 smul_min", 64'(mul_res[0]), 64'h0000_0000_4000_0000);
    issue(1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0003);
    wait_cycles(20);
    check("t2 smul_neg", 64'(mul_res[1]), 64'h0000_0000_FFFF_FFFD);

    issue(1'b1, 1'b1, 16'h0000, 16'h0001, 16'h0000, 16'h8000);
    wait_cycles(20);
    check("t3 sub", 64'(add_res[2]), 64'h0000_0000_FFFF_FFFF);
    check("t3 smul_zero", 64'(mul_res[2]), 64'h0);

    // Req held high for 13 cycles with operands changing while busy.
    for (int k = 0; k < NI; k++) ack_cnt[k] = 0;
    @(posedge clk); #1;
    req = 1'b1;
    for (int c = 0; c < 13; c++) begin
      randomize_inputs();
      @(posedge clk); #1;
    end
    req = 1'b0;
    wait_cycles(30);
    check("t4 acks_steps4", 64'(ack_cnt[2]), 64'd3);
    check("t4 acks_steps1", 64'(ack_cnt[0]), 64'd1);
    check("t4 acks_steps16", 64'(ack_cnt[4]), 64'd5);

    // Reset during MUL cycle 5.
    @(posedge clk); #1;
    add_sel = 1'b0; mul_sel = 1'b0; a0 = 16'h1234; a1 = 16'h1111; m0 = 16'h00FF; m1 = 16'h0101;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 0; k < NI; k++) ack_cnt[k] = 0;
    wait_cycles(4);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    check_idle_zero("t5 rst");
    wait_cycles(25);
    for (int k = 0; k < 3; k++) check($sformatf("t5 no_ack%0d", k), 64'(ack_cnt[k]), 64'd0);
    issue(1'b1, 1'b1, 16'h0100, 16'h0001, 16'h7FFF, 16'h8001);
    wait_cycles(20);
    check("t5 fresh_mul", 64'(mul_res[0]), 64'h0000_0000_C000_FFFF);
    check("t5 fresh_add", 64'(add_res[0]), 64'h0000_0000_0000_00FF);

    for (int i = 0; i < 60; i++) begin
      int hold, gap;
      hold = $urandom_range(1, 3);
      gap  = $urandom_range(0, 20);
      @(posedge clk); #1;
      req = 1'b1;
      for (int c = 0; c < hold; c++) begin
        randomize_inputs();
        @(posedge clk); #1;
      end
      req = 1'b0;
      if (gap > 0) wait_cycles(gap);
    end
    wait_cycles(25);
    for (int k = 0; k < NI; k++) check($sformatf("drain%0d", k), 64'(outstanding[k]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
